// File: rtl/uart_prog_loader.sv
// UART program loader: receives an 8N1 byte stream (A5, 16-bit word count, LE words)
// and writes it into instruction memory while holding the core.
module uart_prog_loader #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned MEM_WORDS    = 512
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        uart_rx,
   output logic        im_we,
   output logic [31:0] im_addr,
   output logic [31:0] im_wdata,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        frame_err
);

   localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
   localparam int unsigned HALF_M1   = (HALF_BIT > 0) ? HALF_BIT - 1 : 0;
   localparam logic [7:0]  SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {
      S_WAIT_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERROR
   } ld_state_t;

   // Two-flop synchronizer; idles high so reset does not look like a start bit
   logic rx_meta, rx_s;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_s    <= rx_meta;
      end
   end

   rx_state_t        rx_state, rx_state_d;
   logic [CNT_W-1:0] rx_cnt;
   logic [2:0]       rx_bit;
   logic [7:0]       rx_shift;
   logic             rx_tick_c;
   logic             rx_stb, rx_ferr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx_state <= RX_IDLE;
      else        rx_state <= rx_state_d;
   end

   // rx_tick_c marks a sample point: mid start bit, then every bit period after
   always_comb begin
      rx_state_d = rx_state;
      rx_tick_c  = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (!rx_s) rx_state_d = RX_START;
         end
         RX_START: begin
            if (rx_cnt == CNT_W'(HALF_M1)) begin
               rx_tick_c  = 1'b1;
               rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
               rx_tick_c = 1'b1;
               if (rx_bit == 3'd7) rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
               rx_tick_c  = 1'b1;
               rx_state_d = RX_IDLE;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_stb   <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_stb  <= 1'b0;
         rx_ferr <= 1'b0;
         if (rx_state == RX_IDLE || rx_tick_c) rx_cnt <= '0;
         else                                  rx_cnt <= rx_cnt + CNT_W'(1);
         if (rx_state == RX_IDLE) rx_bit <= '0;
         if (rx_tick_c && rx_state == RX_DATA) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
         end
         if (rx_tick_c && rx_state == RX_STOP) begin
            if (rx_s) rx_stb  <= 1'b1;
            else      rx_ferr <= 1'b1;
         end
      end
   end

   ld_state_t   state, state_d;
   logic [7:0]  len_lo;
   logic [15:0] word_cnt;
   logic [15:0] idx;
   logic [1:0]  byte_idx;
   logic [31:0] word_q;
   logic [15:0] len_full_c;

   assign len_full_c = {rx_shift, len_lo};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_WAIT_SYNC;
      else        state <= state_d;
   end

   // Framing errors win over everything except the terminal DONE state
   always_comb begin
      state_d = state;
      if (rx_ferr && state != S_DONE) begin
         state_d = S_ERROR;
      end else begin
         case (state)
            S_WAIT_SYNC, S_ERROR: begin
               if (rx_stb && rx_shift == SYNC_BYTE) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
               if (rx_stb) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
               if (rx_stb) begin
                  if (len_full_c == 16'd0 || 32'(len_full_c) > 32'(MEM_WORDS))
                     state_d = S_ERROR;
                  else
                     state_d = S_DATA;
               end
            end
            S_DATA: begin
               if (rx_stb && byte_idx == 2'd3) state_d = S_WRITE;
            end
            S_WRITE: begin
               state_d = (idx + 16'd1 == word_cnt) ? S_DONE : S_DATA;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_WAIT_SYNC;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_lo    <= '0;
         word_cnt  <= '0;
         idx       <= '0;
         byte_idx  <= '0;
         word_q    <= '0;
         im_we     <= 1'b0;
         im_addr   <= '0;
         im_wdata  <= '0;
         cpu_hold  <= 1'b1;
         load_done <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (state_d == S_LEN_LO && state != S_LEN_LO) begin
            idx      <= '0;
            byte_idx <= '0;
         end
         if (state == S_LEN_LO && rx_stb) len_lo <= rx_shift;
         if (state == S_LEN_HI && rx_stb) begin
            word_cnt <= len_full_c;
            idx      <= '0;
            byte_idx <= '0;
         end
         if (state == S_DATA && rx_stb) begin
            word_q   <= {rx_shift, word_q[31:8]};
            byte_idx <= byte_idx + 2'd1;
         end
         im_we <= (state == S_WRITE);
         if (state == S_WRITE) begin
            im_addr  <= {14'd0, idx, 2'b00};
            im_wdata <= word_q;
            idx      <= idx + 16'd1;
         end
         cpu_hold  <= (state_d != S_DONE);
         load_done <= (state_d == S_DONE);
         if (state_d == S_ERROR) frame_err <= 1'b1;
      end
   end

endmodule
